// File: rtl/seq_mult_8x8.sv
// 8x8 unsigned sequential multiplier: one 4x4 partial product per cycle,
// shifted into a 16-bit accumulator, with a 7-segment step indicator.
module seq_mult_8x8 (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic        done_flag,
  output logic [15:0] product_8x8_out,
  output logic [0:6]  segments
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  count, count_nx;
  logic [7:0]  a_reg, b_reg;
  logic [15:0] acc, acc_nx;
  logic        load;

  // Step bit 0 selects the multiplicand nibble, bit 1 the multiplier nibble;
  // the shift is the sum of the two nibble weights.
  function automatic logic [15:0] partial_product(input logic [7:0] a,
                                                  input logic [7:0] b,
                                                  input logic [1:0] step);
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [7:0]  pp;
    logic [15:0] ext;
    a_nib = step[0] ? a[7:4] : a[3:0];
    b_nib = step[1] ? b[7:4] : b[3:0];
    pp    = {4'd0, a_nib} * {4'd0, b_nib};
    ext   = {8'd0, pp};
    case (step)
      2'd0:    return ext;
      2'd3:    return ext << 8;
      default: return ext << 4;
    endcase
  endfunction

  function automatic logic [6:0] seg_decode(input state_t st, input logic [1:0] cnt);
    case (st)
      IDLE: return 7'b1111110;
      CALC: begin
        case (cnt)
          2'd0:    return 7'b0110000;
          2'd1:    return 7'b1101101;
          2'd2:    return 7'b1111001;
          default: return 7'b0110011;
        endcase
      end
      DONE:    return 7'b0111101;
      default: return 7'b1001111;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    count_nx = count;
    acc_nx   = acc;
    load     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load     = 1'b1;
          acc_nx   = 16'd0;
          count_nx = 2'd0;
          state_nx = CALC;
        end
      end
      CALC: begin
        acc_nx   = acc + partial_product(a_reg, b_reg, count);
        count_nx = count + 2'd1;
        if (count == 2'd3) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state <= IDLE;
      count <= 2'd0;
      acc   <= 16'd0;
      a_reg <= 8'd0;
      b_reg <= 8'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      acc   <= acc_nx;
      if (load) begin
        a_reg <= dataa;
        b_reg <= datab;
      end
    end
  end

  assign done_flag       = (state == DONE);
  assign product_8x8_out = acc;
  assign segments        = seg_decode(state, count);

endmodule

// File: tb/tb_seq_mult_8x8.sv
// Scoreboard bench for seq_mult_8x8: directed operand vectors with
// hand-computed products, per-step accumulator and display expectations.
module tb_seq_mult_8x8;

  logic        clk;
  logic        reset_a;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic        done_flag;
  logic [15:0] product_8x8_out;
  logic [0:6]  segments;

  seq_mult_8x8 dut (
    .clk             (clk),
    .reset_a         (reset_a),
    .start           (start),
    .dataa           (dataa),
    .datab           (datab),
    .done_flag       (done_flag),
    .product_8x8_out (product_8x8_out),
    .segments        (segments)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] prod;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic done_q = 1'b0;

  localparam logic [6:0] SEG_IDLE = 7'b1111110;
  logic [6:0] seg_exp [5];
  initial seg_exp = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b0111101};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: every rising done_flag must match the oldest pending request.
  always @(negedge clk) begin
    exp_t e;
    if (done_flag === 1'b1 && done_q !== 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("product", {16'd0, product_8x8_out}, {16'd0, e.prod});
        check("latency", cyc - e.issue, 32'd5);
      end
    end
    done_q = done_flag;
  end

  task automatic check_idle(input string tag);
    check({tag, "_product"}, {16'd0, product_8x8_out}, 32'd0);
    check({tag, "_done"}, {31'd0, done_flag}, 32'd0);
    check({tag, "_seg"}, {25'd0, segments}, {25'd0, SEG_IDLE});
  endtask

  task automatic do_reset();
    reset_a = 1'b1;
    @(posedge clk); #1;
    reset_a = 1'b0;
    sb.delete();
    check_idle("reset");
  endtask

  // Called at posedge+1; the next edge samples start.
  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                          input logic [15:0] s0, input logic [15:0] s1,
                          input logic [15:0] s2, input logic [15:0] s3, input bit poke);
    logic [15:0] steps [4];
    exp_t e;
    steps  = '{s0, s1, s2, s3};
    dataa  = a;
    datab  = b;
    start  = 1'b1;
    e.prod = exp_p;
    e.issue = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    dataa = ~a;
    datab = ~b;
    check("latch_done", {31'd0, done_flag}, 32'd0);
    check("latch_acc", {16'd0, product_8x8_out}, 32'd0);
    check("seg_step0", {25'd0, segments}, {25'd0, seg_exp[0]});
    for (int k = 1; k <= 4; k++) begin
      if (poke && k == 2) begin
        start = 1'b1;
        dataa = 8'd3;
        datab = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("acc_step%0d", k), {16'd0, product_8x8_out}, {16'd0, steps[k-1]});
      check($sformatf("seg_step%0d", k), {25'd0, segments}, {25'd0, seg_exp[k]});
    end
    start = 1'b0;
  endtask

  initial begin
    reset_a = 1'b1;
    start   = 1'b0;
    dataa   = 8'd10;
    datab   = 8'd20;
    @(posedge clk); #1;
    reset_a = 1'b0;
    check_idle("init");

    run_mult(8'd10, 8'd20, 16'd200, 16'd40, 16'd40, 16'd200, 16'd200, 1'b0);
    do_reset();
    run_mult(8'd100, 8'd200, 16'd20000, 16'd32, 16'd800, 16'd1568, 16'd20000, 1'b0);
    run_mult(8'd255, 8'd255, 16'd65025, 16'd225, 16'd3825, 16'd7425, 16'd65025, 1'b0);
    run_mult(8'd0, 8'd173, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    run_mult(8'd1, 8'd255, 16'd255, 16'd15, 16'd15, 16'd255, 16'd255, 1'b0);

    // Abort at the second compute edge.
    dataa = 8'd100;
    datab = 8'd200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_a = 1'b1;
    @(posedge clk); #1;
    reset_a = 1'b0;
    check_idle("abort");
    run_mult(8'd3, 8'd7, 16'd21, 16'd21, 16'd21, 16'd21, 16'd21, 1'b0);

    // Start during CALC is ignored; then restart straight from DONE.
    run_mult(8'd100, 8'd200, 16'd20000, 16'd32, 16'd800, 16'd1568, 16'd20000, 1'b1);
    run_mult(8'd15, 8'd17, 16'd255, 16'd15, 16'd15, 16'd255, 16'd255, 1'b0);

    // Start and reset on the same edge: reset wins and nothing launches.
    dataa   = 8'd9;
    datab   = 8'd9;
    start   = 1'b1;
    reset_a = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    reset_a = 1'b0;
    check_idle("start_reset");
    repeat (8) @(posedge clk);
    #1;
    check_idle("stay_idle");

    check("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound on the run in case the stimulus stalls.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded bound, %0d pending results", sb.size());
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule
